// File: rtl/cheri_err_monitor.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : cheri_err_monitor
// Brief   : Monitors the CHERI exception lines. It keeps a sticky flag for each
//           error class, a saturating per-class occurrence counter, a
//           one-cycle new-error pulse, and a timestamped record of the first
//           error seen.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module cheri_err_monitor #(
   parameter int NumErr   = 9,
   parameter int CntWidth = 8,
   parameter int TsWidth  = 32,
   parameter int IdxW     = (NumErr > 1) ? $clog2(NumErr) : 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [NumErr-1:0]   err_i,
   input  logic                clr_i,
   input  logic [NumErr-1:0]   clr_mask_i,
   input  logic [IdxW-1:0]     rd_idx_i,
   output logic [CntWidth-1:0] rd_count_o,
   output logic [NumErr-1:0]   sticky_o,
   output logic                new_err_o,
   output logic [IdxW-1:0]     new_idx_o,
   output logic                first_valid_o,
   output logic [IdxW-1:0]     first_idx_o,
   output logic [TsWidth-1:0]  first_time_o,
   output logic [TsWidth-1:0]  time_o
);

   localparam logic [CntWidth-1:0] c_cnt_max = '1;

   // Returns the index of the lowest set bit, or 0 when no bit is set.
   function automatic logic [IdxW-1:0] lowest_set(input logic [NumErr-1:0] v);
      lowest_set = '0;
      for (int i = NumErr - 1; i >= 0; i--) begin
         if (v[i]) lowest_set = IdxW'(i);
      end
   endfunction

   logic [TsWidth-1:0]  r_time;
   logic [NumErr-1:0]   r_err;
   logic [NumErr-1:0]   r_sticky;
   logic                r_new_err;
   logic [IdxW-1:0]     r_new_idx;
   logic                r_first_valid;
   logic [IdxW-1:0]     r_first_idx;
   logic [TsWidth-1:0]  r_first_time;
   logic [CntWidth-1:0] r_cnt [NumErr];
   logic [CntWidth-1:0] r_rd_count;

   logic [NumErr-1:0]   w_clrm;
   logic [NumErr-1:0]   w_rise;
   logic [NumErr-1:0]   w_sticky_d;
   logic [NumErr-1:0]   w_newly;
   logic                w_rec_hit;
   logic                w_rec_keep;
   logic [CntWidth-1:0] w_cnt_d [NumErr];
   logic [CntWidth-1:0] w_rd_val;

   // Clear mask, rising edges, sticky next-state and newly-sticky channels.
   always_comb begin
      w_clrm     = clr_i ? clr_mask_i : '0;
      w_rise     = err_i & ~r_err;
      w_sticky_d = (r_sticky & ~w_clrm) | err_i;
      w_newly    = err_i & ~(r_sticky & ~w_clrm);
   end

   // Decide whether the held first-error record survives this cycle's clear.
   always_comb begin
      w_rec_hit = 1'b0;
      for (int c = 0; c < NumErr; c++) begin
         if (r_first_idx == IdxW'(c)) w_rec_hit = w_clrm[c];
      end
      w_rec_keep = r_first_valid && !w_rec_hit;
   end

   // Per-channel counters: clear first, then count the rising edge, saturating.
   always_comb begin
      for (int c = 0; c < NumErr; c++) begin
         w_cnt_d[c] = w_clrm[c] ? '0 : r_cnt[c];
         if (w_rise[c] && (w_cnt_d[c] != c_cnt_max)) w_cnt_d[c] = w_cnt_d[c] + 1'b1;
      end
   end

   // Read mux over the pre-update counters; out-of-range indices read as 0.
   always_comb begin
      w_rd_val = '0;
      for (int c = 0; c < NumErr; c++) begin
         if (rd_idx_i == IdxW'(c)) w_rd_val = r_cnt[c];
      end
   end

   // State registers: timer, edge detector, sticky flags, pulse, record, counters.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_time        <= '0;
         r_err         <= '0;
         r_sticky      <= '0;
         r_new_err     <= 1'b0;
         r_new_idx     <= '0;
         r_first_valid <= 1'b0;
         r_first_idx   <= '0;
         r_first_time  <= '0;
         r_rd_count    <= '0;
         for (int c = 0; c < NumErr; c++) r_cnt[c] <= '0;
      end else begin
         r_time     <= r_time + 1'b1;
         r_err      <= err_i;
         r_sticky   <= w_sticky_d;
         r_new_err  <= |w_newly;
         r_rd_count <= w_rd_val;
         if (|w_newly) r_new_idx <= lowest_set(w_newly);
         // A surviving record is never overwritten; otherwise capture any error.
         if (w_rec_keep) begin
            r_first_valid <= 1'b1;
         end else if (|err_i) begin
            r_first_valid <= 1'b1;
            r_first_idx   <= lowest_set(err_i);
            r_first_time  <= r_time;
         end else begin
            r_first_valid <= 1'b0;
         end
         for (int c = 0; c < NumErr; c++) r_cnt[c] <= w_cnt_d[c];
      end
   end

   assign time_o        = r_time;
   assign sticky_o      = r_sticky;
   assign new_err_o     = r_new_err;
   assign new_idx_o     = r_new_idx;
   assign first_valid_o = r_first_valid;
   assign first_idx_o   = r_first_idx;
   assign first_time_o  = r_first_time;
   assign rd_count_o    = r_rd_count;

endmodule
`default_nettype wire

// File: tb/tb_cheri_err_monitor.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_cheri_err_monitor
// Brief   : Directed self-checking bench for cheri_err_monitor (default params).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_cheri_err_monitor;

   localparam int NumErr   = 9;
   localparam int CntWidth = 8;
   localparam int TsWidth  = 32;
   localparam int IdxW     = 4;

   logic                clk_i;
   logic                rst_ni;
   logic [NumErr-1:0]   err_i;
   logic                clr_i;
   logic [NumErr-1:0]   clr_mask_i;
   logic [IdxW-1:0]     rd_idx_i;
   logic [CntWidth-1:0] rd_count_o;
   logic [NumErr-1:0]   sticky_o;
   logic                new_err_o;
   logic [IdxW-1:0]     new_idx_o;
   logic                first_valid_o;
   logic [IdxW-1:0]     first_idx_o;
   logic [TsWidth-1:0]  first_time_o;
   logic [TsWidth-1:0]  time_o;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_time = 0;
   int pulses;
   int t_cap;

   cheri_err_monitor #(
      .NumErr  (NumErr),
      .CntWidth(CntWidth),
      .TsWidth (TsWidth)
   ) u_dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .err_i        (err_i),
      .clr_i        (clr_i),
      .clr_mask_i   (clr_mask_i),
      .rd_idx_i     (rd_idx_i),
      .rd_count_o   (rd_count_o),
      .sticky_o     (sticky_o),
      .new_err_o    (new_err_o),
      .new_idx_o    (new_idx_o),
      .first_valid_o(first_valid_o),
      .first_idx_o  (first_idx_o),
      .first_time_o (first_time_o),
      .time_o       (time_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Advance one clock edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk_i);
      #1;
      if (rst_ni) exp_time++;
      if (new_err_o) pulses++;
   endtask

   initial begin
      rst_ni = 1'b0; err_i = '0; clr_i = 1'b0; clr_mask_i = '0; rd_idx_i = '0;
      pulses = 0;
      tick(); tick();
      exp_time = 0;
      rst_ni = 1'b1;
      #1;
      check("rst_time",   time_o, 0);
      check("rst_sticky", sticky_o, 0);
      check("rst_new",    new_err_o, 0);
      check("rst_newidx", new_idx_o, 0);
      check("rst_fvalid", first_valid_o, 0);
      check("rst_fidx",   first_idx_o, 0);
      check("rst_ftime",  first_time_o, 0);
      check("rst_rdcnt",  rd_count_o, 0);

      // Idle for 9 edges: time counts, everything else stays zero.
      for (int i = 0; i < 9; i++) begin
         tick();
         check("idle_sticky", sticky_o, 0);
         check("idle_fvalid", first_valid_o, 0);
      end
      check("idle_time9", time_o, 9);
      check("idle_pulses", pulses, 0);

      // Single error sampled at time 20.
      for (int i = 0; i < 11; i++) tick();
      check("t20", time_o, 20);
      err_i = 9'h002;
      tick();
      check("se_new",    new_err_o, 1);
      check("se_newidx", new_idx_o, 1);
      check("se_fvalid", first_valid_o, 1);
      check("se_fidx",   first_idx_o, 1);
      check("se_ftime",  first_time_o, 20);
      check("se_sticky", sticky_o, 9'h002);
      err_i = '0; rd_idx_i = 4'd1;
      tick();
      check("se_pulse_end", new_err_o, 0);
      check("se_newidx_hold", new_idx_o, 1);
      check("se_cnt1", rd_count_o, 1);

      // Modulated channel 0: 300 rising edges saturate the counter.
      pulses = 0;
      for (int i = 0; i < 300; i++) begin
         err_i[0] = 1'b1; tick();
         err_i[0] = 1'b0; tick();
      end
      rd_idx_i = 4'd0;
      tick();
      check("sat_cnt", rd_count_o, 255);
      err_i[0] = 1'b1; tick();
      err_i[0] = 1'b0; tick();
      tick();
      check("sat_hold", rd_count_o, 255);
      check("mod_pulses", pulses, 1);
      check("mod_fidx", first_idx_o, 1);
      check("mod_sticky", sticky_o, 9'h003);

      // Clear everything.
      clr_i = 1'b1; clr_mask_i = 9'h1FF;
      tick();
      clr_i = 1'b0; clr_mask_i = '0;
      check("clrall_sticky", sticky_o, 0);
      check("clrall_fvalid", first_valid_o, 0);
      tick();
      check("clrall_cnt0", rd_count_o, 0);

      // Simultaneous errors on 3 and 7.
      t_cap = exp_time;
      err_i = 9'h088;
      tick();
      check("sim_new",    new_err_o, 1);
      check("sim_newidx", new_idx_o, 3);
      check("sim_fidx",   first_idx_o, 3);
      check("sim_ftime",  first_time_o, t_cap);
      check("sim_sticky", sticky_o, 9'h088);
      tick();
      check("sim_onepulse", new_err_o, 0);
      // Clear channel 3 (the recorded one) while 7 stays high.
      t_cap = exp_time;
      err_i = 9'h080; clr_i = 1'b1; clr_mask_i = 9'h008; rd_idx_i = 4'd3;
      tick();
      clr_i = 1'b0; clr_mask_i = '0;
      check("clr_sticky", sticky_o, 9'h080);
      check("clr_fidx",   first_idx_o, 7);
      check("clr_ftime",  first_time_o, t_cap);
      check("clr_fvalid", first_valid_o, 1);
      check("clr_nopulse", new_err_o, 0);
      check("clr_cnt3_pre", rd_count_o, 1);
      tick();
      check("clr_cnt3", rd_count_o, 0);

      // Clear versus set on channel 4.
      err_i = 9'h090; tick();
      err_i = 9'h080; tick();
      check("cs_pre_sticky", sticky_o, 9'h090);
      err_i = 9'h090; clr_i = 1'b1; clr_mask_i = 9'h010; rd_idx_i = 4'd4;
      tick();
      clr_i = 1'b0; clr_mask_i = '0;
      check("cs_sticky", sticky_o, 9'h090);
      check("cs_new",    new_err_o, 1);
      check("cs_newidx", new_idx_o, 4);
      check("cs_fidx",   first_idx_o, 7);
      tick();
      check("cs_cnt4", rd_count_o, 1);
      check("cs_time", time_o, exp_time);

      // Asynchronous reset in the middle of a cycle.
      #3;
      rst_ni = 1'b0;
      #1;
      check("ar_time",   time_o, 0);
      check("ar_sticky", sticky_o, 0);
      check("ar_fvalid", first_valid_o, 0);
      check("ar_ftime",  first_time_o, 0);
      check("ar_rdcnt",  rd_count_o, 0);
      err_i = '0;
      tick();
      rst_ni = 1'b1; exp_time = 0; rd_idx_i = 4'd9;
      tick();
      check("ar_time1", time_o, 1);
      check("ar_idx9",  rd_count_o, 0);
      check("ar_new",   new_err_o, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
